// File: rtl/spi_status_tx.sv
// spi_status_tx: snapshots N_WORDS status words, appends their XOR checksum and
// shifts the frame out MSB-first, one bit per bit_tick.
module spi_status_tx #(
    parameter int unsigned N_WORDS = 8,
    parameter int unsigned WORD_W  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        snap_req,
    input  logic                        abort,
    input  logic                        bit_tick,
    input  logic [N_WORDS*WORD_W-1:0]   status_i,
    output logic                        miso,
    output logic                        busy,
    output logic                        frame_done,
    output logic [3:0]                  word_idx,
    output logic                        overrun,
    output logic [N_WORDS*WORD_W-1:0]   snapshot_o
);

    localparam int unsigned SNAP_W  = N_WORDS * WORD_W;
    localparam int unsigned FRAME_W = (N_WORDS + 1) * WORD_W;
    localparam int unsigned CNT_W   = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] WORD_DIV = CNT_W'(WORD_W);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t                 state_q;
    // miso_q is the frame MSB; shift_q holds the remaining FRAME_W-1 bits.
    logic [FRAME_W-2:0]     shift_q;
    logic [CNT_W-1:0]       bit_cnt_q;
    logic [CNT_W-1:0]       bit_cnt_d;
    logic [WORD_W-1:0]      chk_d;
    logic                   miso_q;
    logic                   busy_q;
    logic                   frame_done_q;
    logic [3:0]             word_idx_q;
    logic                   overrun_q;
    logic [SNAP_W-1:0]      snapshot_q;

    // XOR checksum over all incoming status words
    always_comb begin
        chk_d = '0;
        for (int unsigned i = 0; i < N_WORDS; i++) begin
            chk_d = chk_d ^ status_i[SNAP_W-1-i*WORD_W -: WORD_W];
        end
    end

    // Bit counter increment
    always_comb begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
    end

    // Frame FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            miso_q       <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            word_idx_q   <= '0;
            overrun_q    <= 1'b0;
            snapshot_q   <= '0;
        end else begin
            frame_done_q <= 1'b0;
            if (snap_req && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end
            if (abort) begin
                // abort beats everything, including a capture in IDLE
                state_q    <= IDLE;
                busy_q     <= 1'b0;
                miso_q     <= 1'b0;
                word_idx_q <= '0;
                bit_cnt_q  <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (snap_req) begin
                            shift_q    <= {status_i[SNAP_W-2:0], chk_d};
                            miso_q     <= status_i[SNAP_W-1];
                            snapshot_q <= status_i;
                            bit_cnt_q  <= '0;
                            word_idx_q <= '0;
                            busy_q     <= 1'b1;
                            overrun_q  <= 1'b0;
                            state_q    <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (bit_tick) begin
                            shift_q <= {shift_q[FRAME_W-3:0], 1'b0};
                            if (bit_cnt_q == LAST_BIT) begin
                                // counter holds at the last bit so it never wraps
                                miso_q       <= 1'b0;
                                frame_done_q <= 1'b1;
                                word_idx_q   <= 4'(N_WORDS);
                                state_q      <= DONE;
                            end else begin
                                miso_q     <= shift_q[FRAME_W-2];
                                bit_cnt_q  <= bit_cnt_d;
                                word_idx_q <= 4'(bit_cnt_d / WORD_DIV);
                            end
                        end
                    end
                    DONE: begin
                        busy_q     <= 1'b0;
                        word_idx_q <= '0;
                        bit_cnt_q  <= '0;
                        state_q    <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign miso       = miso_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign word_idx   = word_idx_q;
    assign overrun    = overrun_q;
    assign snapshot_o = snapshot_q;

endmodule

// File: tb/tb_spi_status_tx.sv
// tb_spi_status_tx: randomized frames checked against a bit-stream reference model.
module tb_spi_status_tx;

    localparam int unsigned N_WORDS = 8;
    localparam int unsigned WORD_W  = 16;
    localparam int unsigned SNAP_W  = N_WORDS * WORD_W;
    localparam int unsigned FRAME_W = (N_WORDS + 1) * WORD_W;
    localparam int unsigned CW      = 144;

    localparam int EV_NONE   = 0;
    localparam int EV_CHANGE = 1;
    localparam int EV_SNAP2  = 2;
    localparam int EV_ABORT  = 3;
    localparam int EV_RESET  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              snap_req;
    logic              abort;
    logic              bit_tick;
    logic [SNAP_W-1:0] status_i;
    logic              miso;
    logic              busy;
    logic              frame_done;
    logic [3:0]        word_idx;
    logic              overrun;
    logic [SNAP_W-1:0] snapshot_o;

    int n_tests = 0;
    int n_fail  = 0;
    int fd_cnt  = 0;
    int cyc     = 0;

    spi_status_tx #(.N_WORDS(N_WORDS), .WORD_W(WORD_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .snap_req   (snap_req),
        .abort      (abort),
        .bit_tick   (bit_tick),
        .status_i   (status_i),
        .miso       (miso),
        .busy       (busy),
        .frame_done (frame_done),
        .word_idx   (word_idx),
        .overrun    (overrun),
        .snapshot_o (snapshot_o)
    );

    always #5 clk = ~clk;

    // Edge counter and frame_done pulse counter
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (frame_done) fd_cnt <= fd_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: the words in order followed by their XOR
    function automatic logic [FRAME_W-1:0] model_frame(input logic [SNAP_W-1:0] st);
        logic [WORD_W-1:0] c;
        c = '0;
        for (int i = 0; i < int'(N_WORDS); i++) c = c ^ st[SNAP_W-1-i*WORD_W -: WORD_W];
        return {st, c};
    endfunction

    task automatic do_frame(input logic [SNAP_W-1:0] st, input int gap,
                            input int ev_kind, input int ev_tick);
        logic [FRAME_W-1:0] exp_f;
        logic [FRAME_W-1:0] obs;
        int fd0;
        int cyc0;
        exp_f = model_frame(st);
        obs   = '0;
        status_i = st;
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        fd0  = fd_cnt;
        cyc0 = cyc;
        check("busy_start", CW'(busy), CW'(1));
        check("miso_first", CW'(miso), CW'(st[SNAP_W-1]));
        check("snap_valid", CW'(snapshot_o), CW'(st));
        check("ovr_clear",  CW'(overrun), CW'(0));
        check("widx_start", CW'(word_idx), CW'(0));
        obs[FRAME_W-1] = miso;
        for (int k = 1; k <= int'(FRAME_W); k++) begin
            if (k > 1) repeat (gap - 1) step();
            bit_tick = 1'b1;
            step();
            bit_tick = 1'b0;
            if (k < int'(FRAME_W)) begin
                obs[FRAME_W-1-k] = miso;
                check("widx", CW'(word_idx), CW'(k / int'(WORD_W)));
            end else begin
                check("fd_pulse",  CW'(frame_done), CW'(1));
                check("miso_done", CW'(miso), CW'(0));
                check("widx_done", CW'(word_idx), CW'(N_WORDS));
                check("busy_done", CW'(busy), CW'(1));
                if (ev_kind == EV_NONE)
                    check("fd_latency", CW'(cyc - cyc0), CW'(1 + (int'(FRAME_W) - 1) * gap));
            end
            if (k == ev_tick) begin
                case (ev_kind)
                    EV_CHANGE: status_i = '1;
                    EV_SNAP2: begin
                        snap_req = 1'b1;
                        step();
                        snap_req = 1'b0;
                        check("ovr_set",  CW'(overrun), CW'(1));
                        check("busy_ovr", CW'(busy), CW'(1));
                    end
                    EV_ABORT: begin
                        abort = 1'b1;
                        step();
                        abort = 1'b0;
                        check("abort_busy", CW'(busy), CW'(0));
                        check("abort_miso", CW'(miso), CW'(0));
                        check("abort_fd",   CW'(frame_done), CW'(0));
                        check("abort_widx", CW'(word_idx), CW'(0));
                        repeat (3) step();
                        check("abort_no_fd", CW'(fd_cnt - fd0), CW'(0));
                        check("abort_snap",  CW'(snapshot_o), CW'(st));
                        return;
                    end
                    EV_RESET: begin
                        snap_req = 1'b1;
                        step();
                        snap_req = 1'b0;
                        check("ovr_pre_rst", CW'(overrun), CW'(1));
                        rst = 1'b1;
                        #1;
                        check("rst_miso", CW'(miso), CW'(0));
                        check("rst_busy", CW'(busy), CW'(0));
                        check("rst_fd",   CW'(frame_done), CW'(0));
                        check("rst_widx", CW'(word_idx), CW'(0));
                        check("rst_ovr",  CW'(overrun), CW'(0));
                        check("rst_snap", CW'(snapshot_o), CW'(0));
                        step();
                        step();
                        rst = 1'b0;
                        for (int j = 0; j < 5; j++) begin
                            bit_tick = 1'b1;
                            step();
                            check("post_rst_busy", CW'(busy), CW'(0));
                            check("post_rst_miso", CW'(miso), CW'(0));
                        end
                        bit_tick = 1'b0;
                        return;
                    end
                    default: ;
                endcase
            end
        end
        step();
        check("busy_fall",  CW'(busy), CW'(0));
        check("fd_single",  CW'(frame_done), CW'(0));
        check("widx_idle",  CW'(word_idx), CW'(0));
        check("stream",     CW'(obs), CW'(exp_f));
        check("snap_hold",  CW'(snapshot_o), CW'(st));
        check("fd_count",   CW'(fd_cnt - fd0), CW'(1));
    endtask

    function automatic logic [SNAP_W-1:0] rand_status();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [SNAP_W-1:0] st;
        rst      = 1'b1;
        snap_req = 1'b0;
        abort    = 1'b0;
        bit_tick = 1'b0;
        status_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_miso", CW'(miso), CW'(0));
        check("reset_busy", CW'(busy), CW'(0));
        check("reset_fd",   CW'(frame_done), CW'(0));
        check("reset_widx", CW'(word_idx), CW'(0));
        check("reset_ovr",  CW'(overrun), CW'(0));
        check("reset_snap", CW'(snapshot_o), CW'(0));
        rst = 1'b0;
        step();

        // ticks while idle do nothing
        bit_tick = 1'b1;
        repeat (3) step();
        bit_tick = 1'b0;
        check("idle_tick_busy", CW'(busy), CW'(0));
        check("idle_tick_miso", CW'(miso), CW'(0));

        // abort beats a simultaneous snap_req in IDLE
        status_i = rand_status();
        snap_req = 1'b1;
        abort    = 1'b1;
        step();
        snap_req = 1'b0;
        abort    = 1'b0;
        check("abort_snap_busy", CW'(busy), CW'(0));
        check("abort_snap_cap",  CW'(snapshot_o), CW'(0));

        for (int i = 0; i < int'(N_WORDS); i++) st[SNAP_W-1-i*WORD_W -: WORD_W] = WORD_W'(i + 1);
        do_frame(st, 4, EV_NONE, 0);
        do_frame({N_WORDS{16'hA5A5}}, 2, EV_CHANGE, 3);
        do_frame(rand_status(), 2, EV_SNAP2, 50);
        do_frame(rand_status(), 1, EV_NONE, 0);
        do_frame(rand_status(), 3, EV_ABORT, 70);
        do_frame(rand_status(), 2, EV_NONE, 0);
        do_frame(rand_status(), 2, EV_RESET, 100);
        do_frame(rand_status(), 1, EV_NONE, 0);
        do_frame('1, 1, EV_NONE, 0);
        for (int r = 0; r < 4; r++) begin
            do_frame(rand_status(), int'($urandom_range(1, 3)), EV_NONE, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_status_tx.md
# spi_status_tx

Transmit side of the host register link. Captures a coherent snapshot of eight 16-bit acquisition status words, appends a 16-bit XOR checksum, and shifts the 144-bit frame out MSB-first, one bit per `bit_tick`, toward the host SPI interface. It is the readback counterpart of the command-register path. It sits between the acquisition/accumulation logic, which supplies status, and the SPI serializer pins.

## Interface
Parameters
- `N_WORDS`, default 8: number of status words per frame.
- `WORD_W`, default 16: width of each status word and of the checksum.

Ports
- `clk`  in  1: system clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `snap_req`  in  1: single-cycle request to capture status and start a frame.
- `abort`  in  1: terminate the current frame; highest priority after `rst`.
- `bit_tick`  in  1: shift enable, already synchronous to `clk`, one pulse per SPI bit.
- `status_i`  in  `N_WORDS*WORD_W`: status words. Word 0 occupies `[N_WORDS*WORD_W-1 -: WORD_W]` and is sent first.
- `miso`  out  1: serial data, MSB-first.
- `busy`  out  1: a frame is in progress.
- `frame_done`  out  1: one-cycle pulse after the last checksum bit has been shifted.
- `word_idx`  out  4: index of the word currently on `miso`, 0..`N_WORDS`; the value `N_WORDS` means the checksum.
- `overrun`  out  1: sticky flag, set when `snap_req` arrives while `busy`.
- `snapshot_o`  out  `N_WORDS*WORD_W`: parallel copy of the last captured status, for debug readback.

## Operation
- The FSM has three states: IDLE, SHIFT, DONE.
- IDLE:
  - `busy` = 0 and `miso` = 0.
  - On `snap_req` = 1: latch `status_i` into the shadow register and `snapshot_o`, compute `chk` = XOR of all `N_WORDS` words, clear the bit counter, and go to SHIFT.
- SHIFT:
  - `miso` = MSB of the shift register; `busy` = 1.
  - Each `bit_tick`: shift left by one and increment `bit_cnt`.
  - The shift register is `(N_WORDS+1)*WORD_W` bits wide: the shadow words followed by `chk`.
  - When `bit_tick` arrives with `bit_cnt` = `(N_WORDS+1)*WORD_W-1`, go to DONE.
- DONE: lasts one cycle. `frame_done` = 1, `busy` = 1, `miso` = 0. Next state is IDLE.
- `word_idx` = `bit_cnt[..] / WORD_W`, i.e. `bit_cnt >> 4` for the default width. It is held at 0 in IDLE and at `N_WORDS` in DONE.
- `status_i` changes after capture have no effect on the frame in progress (snapshot coherence).
- `snap_req` while in SHIFT or DONE: ignored and sets `overrun`. `overrun` clears only on `rst` or on an accepted `snap_req` taken from IDLE.
- `abort` in SHIFT or DONE: next state is IDLE with `busy` = 0 and `miso` = 0. No `frame_done`; `snapshot_o` keeps its value.
- `abort` and `snap_req` in the same IDLE cycle: `abort` wins and no capture happens.
- `bit_tick` in IDLE or DONE: ignored.
- `bit_cnt` width is `$clog2((N_WORDS+1)*WORD_W)`, which is 8 bits for the defaults. It must not wrap within a frame.

## Timing
- Reset values:
  - `miso` = 0, `busy` = 0, `frame_done` = 0, `word_idx` = 0, `overrun` = 0, `snapshot_o` = 0.
  - The FSM is in IDLE; the shift register and `bit_cnt` are 0.
- `snap_req` is sampled at edge N. At N+1: `busy` = 1, `miso` = bit 127 of `status_i` as sampled at N, and `snapshot_o` is valid.
- A `bit_tick` sampled at edge M makes the next bit appear on `miso` at M+1.
- Minimum frame length is 144 `bit_tick` pulses. `frame_done` is high during the cycle after the edge that sampled the 144th tick. `busy` falls one cycle later.
- Back-to-back frames: a `snap_req` one cycle after `frame_done` is accepted, giving a minimum gap of 1 IDLE cycle.
- `rst` asserted mid-frame: all outputs return to reset values asynchronously. A frame is never resumed after reset.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Basic frame: `status_i` = words 0x0001, 0x0002 … 0x0008; `snap_req`; 144 ticks spaced 4 cycles apart.
  - Expect the captured 144-bit `miso` stream to equal the words in order followed by checksum 0x0008.
  - Expect `frame_done` exactly once, and `word_idx` stepping 0→8.
- Coherence: start with `status_i` = all 0xA5A5. Change it to 0xFFFF… after the 3rd tick.
  - Expect the stream to be eight 0xA5A5 words plus checksum 0x0000, and `snapshot_o` to stay all 0xA5A5.
- Overrun: issue a second `snap_req` at tick 50.
  - Expect `overrun` = 1 and the frame unaltered.
  - A subsequent `snap_req` accepted from IDLE clears `overrun` to 0.
- Abort: assert `abort` at tick 70.
  - Expect `busy` = 0 and `miso` = 0 next cycle, no `frame_done`.
  - A new `snap_req` then produces a full 144-bit frame.
- Reset mid-frame: assert `rst` at tick 100.
  - Expect all outputs at reset values immediately, including `snapshot_o` = 0 and `overrun` = 0.
  - After release, `bit_tick` pulses alone produce no activity.
- Tick every cycle (`bit_tick` held at 1) with `status_i` = 0xFFFF in all 8 words.
  - Expect 144 consecutive bits: 128 ones, then checksum 0x0000.
  - Expect `frame_done` at cycle N+145 after `snap_req` at N.
